// File: rtl/pipelined_control_unit_if.sv
// Handshake bundle between the IF/ID front end and the pipeline control unit.
// master drives the instruction and status inputs; slave is the control unit itself.
interface pipelined_control_unit_if #(
    parameter int ALUOP_W = 4,
    parameter int REG_AW  = 5
);
    logic [31:0]        id_instr;
    logic               ex_redirect;
    logic               mem_busy;
    logic               stall;
    logic               flush;
    logic               ex_branch;
    logic               ex_jump;
    logic               ex_alusrc;
    logic [ALUOP_W-1:0] ex_aluop;
    logic               ex_memread;
    logic [REG_AW-1:0]  ex_rd;
    logic               mem_memread;
    logic               mem_memwrite;
    logic [REG_AW-1:0]  mem_rd;
    logic               wb_regwrite;
    logic               wb_memtoreg;
    logic [REG_AW-1:0]  wb_rd;

    modport master (
        output id_instr, ex_redirect, mem_busy,
        input  stall, flush, ex_branch, ex_jump, ex_alusrc, ex_aluop, ex_memread, ex_rd,
               mem_memread, mem_memwrite, mem_rd, wb_regwrite, wb_memtoreg, wb_rd
    );

    modport slave (
        input  id_instr, ex_redirect, mem_busy,
        output stall, flush, ex_branch, ex_jump, ex_alusrc, ex_aluop, ex_memread, ex_rd,
               mem_memread, mem_memwrite, mem_rd, wb_regwrite, wb_memtoreg, wb_rd
    );
endinterface

// File: rtl/pipelined_control_unit.sv
// Decode and ID/EX -> EX/MEM -> MEM/WB control pipeline for a 5-stage RISC-V core,
// with load-use stall counter, redirect bubbles and a global freeze on mem_busy.
module pipelined_control_unit #(
    parameter int ALUOP_W         = 4,
    parameter int REG_AW          = 5,
    parameter int LU_STALL_CYCLES = 1,
    parameter int JAL_EN          = 0
) (
    input logic                     clk,
    input logic                     reset,
    pipelined_control_unit_if.slave bus
);
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] LU_RELOAD = 3'(LU_STALL_CYCLES - 1);

    typedef struct packed {
        logic               branch;
        logic               jump;
        logic               alusrc;
        logic [ALUOP_W-1:0] aluop;
        logic               memread;
        logic               memwrite;
        logic               regwrite;
        logic               memtoreg;
        logic [REG_AW-1:0]  rd;
    } ex_ctrl_t;

    typedef struct packed {
        logic              memread;
        logic              memwrite;
        logic              regwrite;
        logic              memtoreg;
        logic [REG_AW-1:0] rd;
    } mem_ctrl_t;

    typedef struct packed {
        logic              regwrite;
        logic              memtoreg;
        logic [REG_AW-1:0] rd;
    } wb_ctrl_t;

    ex_ctrl_t          dec;
    ex_ctrl_t          idex_q;
    mem_ctrl_t         exmem_q;
    wb_ctrl_t          memwb_q;
    logic [2:0]        cnt_q;
    logic              uses_rs2;
    logic              hz;
    logic              bubble;
    logic [6:0]        opcode;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              unused_instr_bits;

    assign opcode            = bus.id_instr[6:0];
    assign rs1               = REG_AW'(bus.id_instr[19:15]);
    assign rs2               = REG_AW'(bus.id_instr[24:20]);
    assign unused_instr_bits = &{1'b0, bus.id_instr[31:25], bus.id_instr[14:12]};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        dec      = '0;
        uses_rs2 = 1'b0;
        case (opcode)
            OP_R: begin
                dec.regwrite = 1'b1;
                dec.aluop    = ALUOP_W'(2'd2);
                uses_rs2     = 1'b1;
            end
            OP_LD: begin
                dec.memread  = 1'b1;
                dec.memtoreg = 1'b1;
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
            end
            OP_ADDI: begin
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
            end
            OP_SD: begin
                dec.memwrite = 1'b1;
                dec.alusrc   = 1'b1;
                uses_rs2     = 1'b1;
            end
            OP_BEQ: begin
                dec.branch = 1'b1;
                dec.aluop  = ALUOP_W'(2'd1);
                uses_rs2   = 1'b1;
            end
            OP_JAL: begin
                if (JAL_EN != 0) begin
                    dec.jump     = 1'b1;
                    dec.regwrite = 1'b1;
                end
            end
            default: ;
        endcase
        // A non-writing instruction must never look like a hazard source downstream.
        dec.rd = dec.regwrite ? REG_AW'(bus.id_instr[11:7]) : '0;
    end

    assign hz = idex_q.memread && (idex_q.rd != '0) &&
                ((idex_q.rd == rs1) || (uses_rs2 && (idex_q.rd == rs2)));

    // Priority: reset, then freeze, then redirect, then load-use stall.
    always_comb begin
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bubble    = 1'b0;
        if (reset) begin
            bus.stall = 1'b0;
        end else if (bus.mem_busy) begin
            bus.stall = 1'b1;
        end else if (bus.ex_redirect) begin
            bus.flush = 1'b1;
            bubble    = 1'b1;
        end else if ((cnt_q != 3'd0) || hz) begin
            bus.stall = 1'b1;
            bubble    = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every stage samples the pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
            cnt_q   <= 3'd0;
        end else if (!bus.mem_busy) begin
            idex_q  <= bubble ? '0 : dec;
            exmem_q <= '{memread:  idex_q.memread,
                         memwrite: idex_q.memwrite,
                         regwrite: idex_q.regwrite,
                         memtoreg: idex_q.memtoreg,
                         rd:       idex_q.rd};
            memwb_q <= '{regwrite: exmem_q.regwrite,
                         memtoreg: exmem_q.memtoreg,
                         rd:       exmem_q.rd};
            if (bus.ex_redirect)    cnt_q <= 3'd0;
            else if (cnt_q != 3'd0) cnt_q <= cnt_q - 3'd1;
            else if (hz)            cnt_q <= LU_RELOAD;
        end
    end

    assign bus.ex_branch    = idex_q.branch;
    assign bus.ex_jump      = idex_q.jump;
    assign bus.ex_alusrc    = idex_q.alusrc;
    assign bus.ex_aluop     = idex_q.aluop;
    assign bus.ex_memread   = idex_q.memread;
    assign bus.ex_rd        = idex_q.rd;
    assign bus.mem_memread  = exmem_q.memread;
    assign bus.mem_memwrite = exmem_q.memwrite;
    assign bus.mem_rd       = exmem_q.rd;
    assign bus.wb_regwrite  = memwb_q.regwrite;
    assign bus.wb_memtoreg  = memwb_q.memtoreg;
    assign bus.wb_rd        = memwb_q.rd;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// Two control units (1-cycle stall/no JAL and 3-cycle stall/JAL) driven in lockstep,
// each compared every cycle against an instruction-level reference model.
module tb_pipelined_control_unit;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef struct packed {
        logic       stall, flush, ex_branch, ex_jump, ex_alusrc;
        logic [3:0] ex_aluop;
        logic       ex_memread;
        logic [4:0] ex_rd;
        logic       mem_memread, mem_memwrite;
        logic [4:0] mem_rd;
        logic       wb_regwrite, wb_memtoreg;
        logic [4:0] wb_rd;
    } obs_t;

    // One instruction's control intent as it travels down the pipe.
    typedef struct {
        bit br, jmp, src;
        int op;
        bit mr, mw, rw, m2r;
        int rd;
    } bun_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipelined_control_unit_if #(.ALUOP_W(4), .REG_AW(5)) bus_a ();
    pipelined_control_unit_if #(.ALUOP_W(4), .REG_AW(5)) bus_b ();

    pipelined_control_unit #(.ALUOP_W(4), .REG_AW(5), .LU_STALL_CYCLES(1), .JAL_EN(0)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a));
    pipelined_control_unit #(.ALUOP_W(4), .REG_AW(5), .LU_STALL_CYCLES(3), .JAL_EN(1)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b));

    obs_t obs [2];
    assign obs[0] = {bus_a.stall, bus_a.flush, bus_a.ex_branch, bus_a.ex_jump, bus_a.ex_alusrc,
                     bus_a.ex_aluop, bus_a.ex_memread, bus_a.ex_rd, bus_a.mem_memread,
                     bus_a.mem_memwrite, bus_a.mem_rd, bus_a.wb_regwrite, bus_a.wb_memtoreg, bus_a.wb_rd};
    assign obs[1] = {bus_b.stall, bus_b.flush, bus_b.ex_branch, bus_b.ex_jump, bus_b.ex_alusrc,
                     bus_b.ex_aluop, bus_b.ex_memread, bus_b.ex_rd, bus_b.mem_memread,
                     bus_b.mem_memwrite, bus_b.mem_rd, bus_b.wb_regwrite, bus_b.wb_memtoreg, bus_b.wb_rd};

    int total = 0;
    int bad   = 0;

    int   lu  [2] = '{1, 3};
    bit   jal [2] = '{1'b0, 1'b1};
    bun_t pipe [2][3];
    int   cnt [2];

    logic [31:0] cur_instr;
    bit          cur_redir, cur_busy, cur_rst;
    bit          st [2];
    bit          fl [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int rs1, input int rs2);
        logic [31:0] w;
        w        = '0;
        w[6:0]   = op;
        w[11:7]  = 5'(rd);
        w[19:15] = 5'(rs1);
        w[24:20] = 5'(rs2);
        return w;
    endfunction

    function automatic bun_t zero_bun();
        bun_t b;
        b = '{default: 0};
        return b;
    endfunction

    function automatic bun_t decode(input int d, input logic [31:0] ins);
        bun_t b;
        b = zero_bun();
        case (ins[6:0])
            OP_R:    begin b.rw = 1; b.op = 2; end
            OP_LD:   begin b.mr = 1; b.m2r = 1; b.src = 1; b.rw = 1; end
            OP_ADDI: begin b.src = 1; b.rw = 1; end
            OP_SD:   begin b.mw = 1; b.src = 1; end
            OP_BEQ:  begin b.br = 1; b.op = 1; end
            OP_JAL:  if (jal[d]) begin b.jmp = 1; b.rw = 1; end
            default: ;
        endcase
        b.rd = b.rw ? int'(ins[11:7]) : 0;
        return b;
    endfunction

    function automatic bit hazard(input int d, input logic [31:0] ins);
        bun_t e;
        bit   two;
        e   = pipe[d][0];
        two = (ins[6:0] == OP_R) || (ins[6:0] == OP_SD) || (ins[6:0] == OP_BEQ);
        return e.mr && (e.rd != 0) &&
               ((e.rd == int'(ins[19:15])) || (two && (e.rd == int'(ins[24:20]))));
    endfunction

    function automatic obs_t expect_obs(input int d);
        obs_t o;
        o = '0;
        if (!cur_rst) begin
            if (cur_busy)       o.stall = 1'b1;
            else if (cur_redir) o.flush = 1'b1;
            else                o.stall = (cnt[d] > 0) || hazard(d, cur_instr);
        end
        o.ex_branch    = pipe[d][0].br;
        o.ex_jump      = pipe[d][0].jmp;
        o.ex_alusrc    = pipe[d][0].src;
        o.ex_aluop     = 4'(pipe[d][0].op);
        o.ex_memread   = pipe[d][0].mr;
        o.ex_rd        = 5'(pipe[d][0].rd);
        o.mem_memread  = pipe[d][1].mr;
        o.mem_memwrite = pipe[d][1].mw;
        o.mem_rd       = 5'(pipe[d][1].rd);
        o.wb_regwrite  = pipe[d][2].rw;
        o.wb_memtoreg  = pipe[d][2].m2r;
        o.wb_rd        = 5'(pipe[d][2].rd);
        return o;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int s = 0; s < 3; s++) pipe[d][s] = zero_bun();
            cnt[d] = 0;
        end
    endtask

    task automatic model_edge(input int d);
        bun_t nb, m, w;
        bit   hz;
        if (cur_busy) return;
        hz = hazard(d, cur_instr);
        nb = (cur_redir || cnt[d] > 0 || hz) ? zero_bun() : decode(d, cur_instr);
        w     = zero_bun();
        w.rw  = pipe[d][1].rw;
        w.m2r = pipe[d][1].m2r;
        w.rd  = pipe[d][1].rd;
        m     = zero_bun();
        m.mr  = pipe[d][0].mr;
        m.mw  = pipe[d][0].mw;
        m.rw  = pipe[d][0].rw;
        m.m2r = pipe[d][0].m2r;
        m.rd  = pipe[d][0].rd;
        pipe[d][2] = w;
        pipe[d][1] = m;
        pipe[d][0] = nb;
        if (cur_redir)       cnt[d] = 0;
        else if (cnt[d] > 0) cnt[d] = cnt[d] - 1;
        else if (hz)         cnt[d] = lu[d] - 1;
    endtask

    task automatic cmp_all(input int d);
        obs_t  e, g;
        string p;
        e = expect_obs(d);
        g = obs[d];
        p = (d == 0) ? "a" : "b";
        check({p, ".stall"},        32'(g.stall),        32'(e.stall));
        check({p, ".flush"},        32'(g.flush),        32'(e.flush));
        check({p, ".ex_branch"},    32'(g.ex_branch),    32'(e.ex_branch));
        check({p, ".ex_jump"},      32'(g.ex_jump),      32'(e.ex_jump));
        check({p, ".ex_alusrc"},    32'(g.ex_alusrc),    32'(e.ex_alusrc));
        check({p, ".ex_aluop"},     32'(g.ex_aluop),     32'(e.ex_aluop));
        check({p, ".ex_memread"},   32'(g.ex_memread),   32'(e.ex_memread));
        check({p, ".ex_rd"},        32'(g.ex_rd),        32'(e.ex_rd));
        check({p, ".mem_memread"},  32'(g.mem_memread),  32'(e.mem_memread));
        check({p, ".mem_memwrite"}, 32'(g.mem_memwrite), 32'(e.mem_memwrite));
        check({p, ".mem_rd"},       32'(g.mem_rd),       32'(e.mem_rd));
        check({p, ".wb_regwrite"},  32'(g.wb_regwrite),  32'(e.wb_regwrite));
        check({p, ".wb_memtoreg"},  32'(g.wb_memtoreg),  32'(e.wb_memtoreg));
        check({p, ".wb_rd"},        32'(g.wb_rd),        32'(e.wb_rd));
        st[d] = g.stall;
        fl[d] = g.flush;
    endtask

    task automatic drive(input logic [31:0] ins, input bit redir, input bit busy);
        bus_a.id_instr = ins; bus_a.ex_redirect = redir; bus_a.mem_busy = busy;
        bus_b.id_instr = ins; bus_b.ex_redirect = redir; bus_b.mem_busy = busy;
        cur_instr = ins;
        cur_redir = redir;
        cur_busy  = busy;
    endtask

    // Starts and ends just after a falling edge.
    task automatic step(input logic [31:0] ins, input bit redir = 1'b0, input bit busy = 1'b0);
        drive(ins, redir, busy);
        #1;
        cmp_all(0);
        cmp_all(1);
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        @(negedge clk);
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        cur_rst  = 1'b1;
        #1;
        model_reset();
        cmp_all(0);
        cmp_all(1);
        check("rst.obs_a", 32'(obs[0]), 32'd0);
        check("rst.obs_b", 32'(obs[1]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset   = 1'b0;
        cur_rst = 1'b0;
    endtask

    initial begin : stim
        int sa, sb;
        logic [6:0] ops [8];
        ops = '{OP_R, OP_LD, OP_ADDI, OP_SD, OP_BEQ, OP_JAL, 7'b1110011, OP_LD};
        reset   = 1'b1;
        cur_rst = 1'b1;
        model_reset();
        drive(mk(OP_R, 3, 1, 2), 1'b1, 1'b1);
        @(negedge clk);

        // Reset with R-type, redirect and busy all present: every output must be low.
        async_reset();
        step(mk(OP_R, 3, 1, 2));
        check("rst.ex_aluop_edge1", 32'(obs[0].ex_aluop), 32'd2);
        step(mk(OP_R, 3, 1, 2));
        step(mk(OP_R, 3, 1, 2));
        check("rst.wb_regwrite_edge3", 32'(obs[0].wb_regwrite), 32'd1);

        // Load-use: 1 bubble on dut_a, 3 on dut_b.
        step(mk(OP_LD, 5, 1, 0));
        sa = 0; sb = 0;
        for (int i = 0; i < 5; i++) begin
            step(mk(OP_R, 6, 5, 1));
            sa += int'(st[0]);
            sb += int'(st[1]);
            if (i == 0) check("lu.bubble_rd_a", 32'(obs[0].ex_rd), 32'd0);
            if (i == 1) check("lu.add_rd_a", 32'(obs[0].ex_rd), 32'd6);
        end
        check("lu.stall_cycles_a", 32'(sa), 32'd1);
        check("lu.stall_cycles_b", 32'(sb), 32'd3);

        // No false hazard on x0 or on an unused rs2 field.
        step(mk(OP_LD, 0, 1, 0));
        step(mk(OP_R, 6, 0, 0));
        check("nohz.x0_a", 32'(st[0]), 32'd0);
        check("nohz.x0_b", 32'(st[1]), 32'd0);
        step(mk(OP_LD, 5, 1, 0));
        step(mk(OP_ADDI, 7, 9, 5));
        check("nohz.rs2_a", 32'(st[0]), 32'd0);
        check("nohz.rs2_b", 32'(st[1]), 32'd0);

        // Taken branch.
        step(mk(OP_BEQ, 0, 1, 2));
        step(mk(OP_ADDI, 8, 1, 0), 1'b1);
        check("br.flush_a", 32'(fl[0]), 32'd1);
        check("br.stall_a", 32'(st[0]), 32'd0);
        check("br.ex_branch_a", 32'(obs[0].ex_branch), 32'd0);
        check("br.ex_rd_a", 32'(obs[0].ex_rd), 32'd0);

        // Redirect in the 2nd cycle of dut_b's 3-cycle stall.
        step(mk(OP_LD, 5, 1, 0));
        step(mk(OP_R, 6, 5, 1));
        check("rdst.first_stall_b", 32'(st[1]), 32'd1);
        step(mk(OP_R, 6, 5, 1), 1'b1);
        check("rdst.stall_drop_b", 32'(st[1]), 32'd0);
        check("rdst.flush_b", 32'(fl[1]), 32'd1);
        step(mk(OP_ADDI, 7, 9, 0));
        check("rdst.cnt_clear_b", 32'(st[1]), 32'd0);

        // Freeze with sd in EX/MEM.
        step(mk(OP_SD, 0, 2, 3));
        step(mk(OP_ADDI, 9, 1, 0));
        for (int i = 0; i < 4; i++) begin
            step(mk(OP_ADDI, 10, 1, 0), 1'b0, 1'b1);
            check("busy.memwrite_a", 32'(obs[0].mem_memwrite), 32'd1);
            check("busy.stall_b", 32'(st[1]), 32'd1);
        end
        step(mk(OP_ADDI, 10, 1, 0));
        check("busy.resume_memwrite_a", 32'(obs[0].mem_memwrite), 32'd0);
        check("busy.resume_mem_rd_a", 32'(obs[0].mem_rd), 32'd9);

        // JAL enabled on dut_b only.
        step(mk(OP_JAL, 1, 0, 0));
        check("jal.ex_jump_b", 32'(obs[1].ex_jump), 32'd1);
        check("jal.nop_bundle_a", 32'(obs[0].ex_jump) | 32'(obs[0].ex_rd), 32'd0);
        step(mk(7'b0000000, 0, 0, 0));
        step(mk(7'b0000000, 0, 0, 0));
        check("jal.wb_regwrite_b", 32'(obs[1].wb_regwrite), 32'd1);
        check("jal.wb_regwrite_a", 32'(obs[0].wb_regwrite), 32'd0);

        // Reset in the middle of a stall, then normal decode resumes.
        step(mk(OP_LD, 4, 1, 0));
        step(mk(OP_R, 6, 4, 4));
        async_reset();
        step(mk(OP_ADDI, 11, 4, 0));
        check("rstmid.ex_rd_b", 32'(obs[1].ex_rd), 32'd11);

        // Randomized traffic over a small register window so hazards are frequent.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] w;
            w        = $urandom;
            w[6:0]   = ops[$urandom_range(0, 7)];
            w[11:7]  = 5'($urandom_range(0, 7));
            w[19:15] = 5'($urandom_range(0, 7));
            w[24:20] = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 255) == 0) async_reset();
            else step(w, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Next-generation control for the 5-stage RISC-V pipeline.
- Decodes the IF/ID instruction into a control bundle and carries that bundle, plus the destination register, through the ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use hazards and generates a stall of configurable length; inserts bubbles on taken branches/jumps.
- Freezes all control state while data memory reports busy.

Parameters:
- ALUOP_W, 4, width of ALUOp; must be ≥2; codes zero-extended to this width.
- REG_AW, 5, register-address width.
- LU_STALL_CYCLES, 1, bubbles inserted per load-use hazard; range 1..7.
- JAL_EN, 0, when 1 decode JAL (opcode 1101111); when 0 JAL decodes as NOP.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- id_instr  in  32  IF/ID instruction: opcode [6:0], rd [11:7], rs1 [19:15], rs2 [24:20].
- ex_redirect  in  1  EX stage resolved a taken branch or jump this cycle.
- mem_busy  in  1  data memory not ready; freeze the pipeline.
- stall  out  1  hold PC and IF/ID.
- flush  out  1  clear IF/ID to NOP.
- ex_branch, ex_jump, ex_alusrc  out  1 each  ID/EX control.
- ex_aluop  out  ALUOP_W  ID/EX ALUOp.
- ex_memread  out  1  ID/EX MemRead, also used by hazard detection.
- ex_rd  out  REG_AW  ID/EX destination register.
- mem_memread, mem_memwrite  out  1 each  EX/MEM control.
- mem_rd  out  REG_AW  EX/MEM destination register.
- wb_regwrite, wb_memtoreg  out  1 each  MEM/WB control.
- wb_rd  out  REG_AW  MEM/WB destination register.

Behaviour:
- Decode (combinational; fields not set are 0, no X outputs):
  - R 0110011: RegWrite; ALUOp=2.
  - ld 0000011: MemRead, MemtoReg, ALUSrc, RegWrite; ALUOp=0.
  - addi 0010011: ALUSrc, RegWrite; ALUOp=0.
  - sd 0100011: MemWrite, ALUSrc; ALUOp=0.
  - beq 1100011: Branch; ALUOp=1.
  - jal 1101111 with JAL_EN=1: Jump, RegWrite; ALUOp=0.
  - Any other opcode: all zero (NOP).
- rs2 is used only by R, sd and beq. rd is forced to 0 when the decoded RegWrite=0.
- Reset (async): every control register, all rd fields and the stall counter clear to 0. stall=0, flush=0 immediately.
- Control registers update each rising edge unless mem_busy=1. When mem_busy=1, all registers and the counter hold, stall=1, flush=0.
- Hazard: hz = ex_memread & (ex_rd≠0) & (ex_rd==rs1 | (uses_rs2 & ex_rd==rs2)).
- Stall counter cnt (3 bits):
  - If cnt==0 and hz and not ex_redirect: stall=1, a bubble (all-zero bundle, rd=0) enters ID/EX, and cnt loads LU_STALL_CYCLES-1.
  - While cnt>0: stall=1, bubble enters ID/EX, cnt decrements.
  - With LU_STALL_CYCLES=1 the hazard costs exactly one cycle.
- Redirect (ex_redirect=1, mem_busy=0):
  - flush=1 and a bubble enters ID/EX.
  - cnt clears to 0 and stall=0; redirect has priority over hazard and over an in-progress stall.
- Normal advance: decoded bundle → ID/EX; ID/EX mem/wb fields → EX/MEM; EX/MEM wb fields → MEM/WB. Latency from decode to a wb_* output is 3 edges.
- The stall and flush outputs are combinational from the current state and inputs; all pipeline outputs are registered.
- Reset asserted mid-stall or mid-freeze: all state clears; the first edge after release resumes normal decode.

Test Plan:
- Reset sequence:
  - Stimulus: reset=1 with id_instr=R-type.
  - Required: all outputs 0.
  - Stimulus: release reset.
  - Required: ex_aluop=2 after edge 1; wb_regwrite=1 after edge 3.
- Load-use hazard:
  - Stimulus: ld x5 followed by add x6,x5,x1.
  - Required: stall=1 for exactly 1 cycle; ID/EX holds a bubble (ex_rd=0); the add reaches ex_rd=6 one cycle later.
  - Stimulus: repeat with LU_STALL_CYCLES=3.
  - Required: 3 stall cycles.
- No false hazard:
  - Stimulus: ld x0 then add using x0; also ld x5 then addi x7,x9 (x5 appears only in rs2 field).
  - Required: stall=0 in both cases.
- Taken branch:
  - Stimulus: beq in EX with ex_redirect=1.
  - Required: flush=1, stall=0, next ex_branch=0 and ex_rd=0.
  - Stimulus: assert ex_redirect during the 2nd cycle of a 3-cycle stall.
  - Required: stall drops that cycle and cnt=0.
- Memory busy:
  - Stimulus: mem_busy=1 for 4 cycles with sd in EX/MEM.
  - Required: mem_memwrite stays 1 and all stage registers are unchanged; stall=1; pipeline resumes on the first edge after mem_busy falls.
- JAL:
  - Stimulus: opcode 1101111 with JAL_EN=1.
  - Required: ex_jump=1 and wb_regwrite=1 three edges later.
  - Stimulus: same opcode with JAL_EN=0.
  - Required: all-zero bundle.
